// File: rtl/cva6_fifo_pkg.sv
// Shared definitions for the cva6 FIFO read-side drain stage.
//   MaxPopLatency    : largest supported upstream read latency (cycles)
//   buf_depth()      : skid-buffer depth needed for a given read latency
//   pop_stage_perf_t : bundle of the optional performance outputs
package cva6_fifo_pkg;

  localparam int unsigned MaxPopLatency = 1;

  // One entry covers the registered output, one covers the pop issued
  // while the consumer stalls, plus one per cycle of read latency.
  function automatic int unsigned buf_depth(input int unsigned lat);
    return lat + 2;
  endfunction

  typedef struct packed {
    logic [31:0] stall_cnt;
    logic        starve;
  } pop_stage_perf_t;

endpackage

// File: rtl/cva6_pop_skid_buf.sv
// Circular skid buffer of DEPTH entries (DEPTH need not be a power of two).
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   flush_i         : synchronous clear of pointers and occupancy
//   wr_en_i/wdata_i : write one entry at the tail
//   rd_en_i         : consume the head entry (ignored when empty)
//   rdata_o         : head entry, straight from the storage array
//   occupancy_o     : number of stored entries, 0..DEPTH
module cva6_pop_skid_buf
  import cva6_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type dtype = logic [31:0],
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned OccW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            wr_en_i,
  input  dtype            wdata_i,
  input  logic            rd_en_i,
  output dtype            rdata_o,
  output logic [OccW-1:0] occupancy_o
);

  dtype            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic            do_rd;

  // Explicit wrap at the last index: DEPTH=3 is not a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_rd = rd_en_i && (occ_q != '0);

  always_comb begin
    wr_ptr_d = wr_en_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q;
    case ({wr_en_i, do_rd})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

  assign rdata_o     = mem_q[rd_ptr_q];
  assign occupancy_o = occ_q;

  // The credit logic upstream must never write into a full buffer
  // unless the head is leaving in the same cycle.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(wr_en_i && !do_rd && (occ_q == OccW'(DEPTH))));

endmodule

// File: rtl/cva6_fifo_pop_stage.sv
// Read-side drain stage for a cva6_fifo_v3-style queue. Pops the upstream
// FIFO under a credit rule, absorbs 0 or 1 cycle of read latency and
// presents a registered valid/ready stream.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   flush_i              : synchronous flush of buffered and in-flight data
//   fifo_empty_i         : upstream empty flag
//   fifo_data_i          : upstream read data
//   fifo_pop_o           : pop request to upstream (combinational)
//   valid_o/ready_i      : consumer handshake
//   data_o               : head of the skid buffer
//   occupancy_o          : buffered entry count
// Optional (macro CVA6_FIFO_POP_STAGE_PERF_EN):
//   stall_cnt_o          : saturating count of valid_o & !ready_i cycles
//   starve_o             : !valid_o & fifo_empty_i
module cva6_fifo_pop_stage
  import cva6_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned BUF_DEPTH    = buf_depth(READ_LATENCY)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        fifo_empty_i,
  input  dtype        fifo_data_i,
  output logic        fifo_pop_o,
  output logic        valid_o,
  input  logic        ready_i,
  output dtype        data_o,
  output logic [1:0]  occupancy_o
`ifdef CVA6_FIFO_POP_STAGE_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic        starve_o
`endif
);

  if (READ_LATENCY > MaxPopLatency) begin : gen_bad_latency
    $error("cva6_fifo_pop_stage: READ_LATENCY must be 0 or 1");
  end

  logic       inflight;
  logic       arrive;
  logic       wr_en;
  logic [1:0] occ;
  logic [2:0] credit_used;

  // Credits count buffered plus in-flight entries; ready_i deliberately
  // does not participate so the pop has no path from the consumer.
  assign credit_used = {1'b0, occ} + {2'b00, inflight};
  assign fifo_pop_o  = !fifo_empty_i && !flush_i && (credit_used < 3'(BUF_DEPTH));

  if (READ_LATENCY == 0) begin : gen_lat0
    assign inflight = 1'b0;
    assign arrive   = fifo_pop_o;
  end else begin : gen_lat1
    logic pipe_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pipe_q <= 1'b0;
      end else begin
        pipe_q <= flush_i ? 1'b0 : fifo_pop_o;
      end
    end
    assign inflight = pipe_q;
    assign arrive   = pipe_q;
  end

  // Data landing in the flush cycle belongs to the flushed stream.
  assign wr_en = arrive && !flush_i;

  cva6_pop_skid_buf #(
    .DEPTH (BUF_DEPTH),
    .dtype (dtype)
  ) u_skid_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .wr_en_i     (wr_en),
    .wdata_i     (fifo_data_i),
    .rd_en_i     (valid_o && ready_i),
    .rdata_o     (data_o),
    .occupancy_o (occ)
  );

  assign valid_o     = (occ != '0);
  assign occupancy_o = occ;

`ifdef CVA6_FIFO_POP_STAGE_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (flush_i) begin
      stall_cnt_q <= '0;
    end else if (valid_o && !ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign starve_o    = !valid_o && fifo_empty_i;
`endif

endmodule

// File: tb/tb_cva6_fifo_pop_stage.sv
module tb_cva6_fifo_pop_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Lane A: READ_LATENCY=0, lane B: READ_LATENCY=1.
  logic        flushA, readyA, popA, validA, emptyA;
  logic [31:0] dataA_in, dataA;
  logic [1:0]  occA;
  logic        flushB, readyB, popB, validB, emptyB;
  logic [31:0] dB, dataB;
  logic [1:0]  occB;

  // Upstream FIFO models; they share the DUT reset and empty on it.
  logic [31:0] memA [64];
  logic [31:0] memB [64];
  int unsigned wrA = 0, rdA = 0, wrB = 0, rdB = 0;

  assign emptyA   = (wrA == rdA);
  assign emptyB   = (wrB == rdB);
  assign dataA_in = memA[rdA[5:0]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdA <= wrA;
      rdB <= wrB;
      dB  <= '0;
    end else begin
      if (popA) rdA <= rdA + 1;
      if (popB) begin
        dB  <= memB[rdB[5:0]];
        rdB <= rdB + 1;
      end
    end
  end

`ifdef CVA6_FIFO_POP_STAGE_PERF_EN
  logic [31:0] stallA, stallB;
  logic        starveA, starveB;
`endif

  cva6_fifo_pop_stage #(.DATA_WIDTH(32), .READ_LATENCY(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flushA), .fifo_empty_i(emptyA),
    .fifo_data_i(dataA_in), .fifo_pop_o(popA), .valid_o(validA),
    .ready_i(readyA), .data_o(dataA), .occupancy_o(occA)
`ifdef CVA6_FIFO_POP_STAGE_PERF_EN
    , .stall_cnt_o(stallA), .starve_o(starveA)
`endif
  );

  cva6_fifo_pop_stage #(.DATA_WIDTH(32), .READ_LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flushB), .fifo_empty_i(emptyB),
    .fifo_data_i(dB), .fifo_pop_o(popB), .valid_o(validB),
    .ready_i(readyB), .data_o(dataB), .occupancy_o(occB)
`ifdef CVA6_FIFO_POP_STAGE_PERF_EN
    , .stall_cnt_o(stallB), .starve_o(starveB)
`endif
  );

  // Scoreboards: values leave the upstream model on a pop and must come
  // out of the DUT in the same order unless flushed or reset.
  logic [31:0] expA[$];
  logic [31:0] expB[$];
  logic        prevPopB = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    int unsigned used;
    if (!rst_n) begin
      expA.delete();
      expB.delete();
      prevPopB = 1'b0;
      return;
    end
    if (validA && readyA) begin
      check("sbA_expected_beat", (expA.size() != 0), 1);
      if (expA.size() != 0) check("sbA_data", dataA, expA.pop_front());
    end
    if (popA) expA.push_back(memA[rdA[5:0]]);
    if (flushA) expA.delete();

    if (validB && readyB) begin
      check("sbB_expected_beat", (expB.size() != 0), 1);
      if (expB.size() != 0) check("sbB_data", dataB, expB.pop_front());
    end
    used = int'(occB) + int'(prevPopB);
    check("creditB", (popB && used == 3), 0);
    if (popB) expB.push_back(memB[rdB[5:0]]);
    if (flushB) expB.delete();
    prevPopB = popB;
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      sample();
      next();
    end
  endtask

  task automatic pushA(input logic [31:0] v);
    memA[wrA[5:0]] = v;
    wrA++;
  endtask

  task automatic pushB(input logic [31:0] v);
    memB[wrB[5:0]] = v;
    wrB++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t1d [3];
    int unsigned pops, beats;
    logic        got;
    t1d[0] = 32'h11; t1d[1] = 32'h22; t1d[2] = 32'h33;

    rst_n = 1'b0; flushA = 1'b0; flushB = 1'b0; readyA = 1'b0; readyB = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sample();
    check("rst_validA", validA, 0); check("rst_occA", occA, 0);
    check("rst_dataA", dataA, 0);   check("rst_popA", popA, 0);
    check("rst_validB", validB, 0); check("rst_occB", occB, 0);
    check("rst_dataB", dataB, 0);   check("rst_popB", popB, 0);
    rst_n = 1'b1;
    next();

    // Latency 0: three preloaded entries, no bubbles.
    readyA = 1'b1;
    pushA(32'h11); pushA(32'h22); pushA(32'h33);
    for (int c = 0; c <= 4; c++) begin
      sample();
      check("t1_pop", popA, (c <= 2));
      check("t1_valid", validA, (c >= 1 && c <= 3));
      if (c >= 1 && c <= 3) check("t1_data", dataA, t1d[c-1]);
      next();
    end

    // Latency 1: eight entries, first beat at cycle 2, then back to back.
    readyB = 1'b1;
    for (int i = 0; i < 8; i++) pushB(i);
    for (int c = 0; c <= 10; c++) begin
      sample();
      check("t2_valid", validB, (c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) check("t2_data", dataB, c - 2);
      next();
    end

    // Latency 1 with consumer stalled: exactly three pops, head held.
    readyB = 1'b0;
    pops = 0;
    for (int i = 8; i < 18; i++) pushB(i);
    for (int c = 0; c < 10; c++) begin
      sample();
      if (popB) pops++;
      if (c >= 2) check("t3_hold", dataB, 8);
      next();
    end
    check("t3_pops", pops, 3);
    check("t3_occ", occB, 3);
    readyB = 1'b1;
    beats = 0;
    for (int c = 0; c < 30; c++) begin
      sample();
      if (validB && readyB) beats++;
      next();
      if (emptyB && occB == 0 && expB.size() == 0) break;
    end
    check("t3_beats", beats, 10);
    check("t3_drain", expB.size(), 0);
    check("t3_occ_end", occB, 0);

    // Flush with a full buffer.
    readyB = 1'b0;
    pushB(32'h91); pushB(32'h92); pushB(32'h93);
    cyc(4);
    check("t4_full", occB, 3);
    flushB = 1'b1;
    sample();
    next();
    flushB = 1'b0;
    check("t4_valid_after_flush", validB, 0);
    check("t4_occ_after_flush", occB, 0);

    // Flush in the cycle the popped data returns, then refill with 0xA0.
    pushB(32'h55);
    sample();
    check("t4_pop55", popB, 1);
    next();
    flushB = 1'b1;
    sample();
    next();
    flushB = 1'b0;
    sample();
    check("t4_drop_valid", validB, 0);
    check("t4_drop_occ", occB, 0);
    next();
    sample();
    check("t4_drop_late", validB, 0);
    next();
    readyB = 1'b1;
    pushB(32'hA0);
    got = 1'b0;
    for (int c = 0; c < 6; c++) begin
      sample();
      if (validB) begin
        check("t4_first_after_flush", dataB, 32'hA0);
        got = 1'b1;
      end
      next();
      if (got) break;
    end
    check("t4_a0_seen", got, 1);
    cyc(2);

    // Latency 0: flush suppresses the pop of a non-empty FIFO.
    readyA = 1'b0;
    flushA = 1'b1;
    pushA(32'h77);
    sample();
    check("tA_pop_in_flush", popA, 0);
    next();
    flushA = 1'b0;
    sample();
    check("tA_pop_after_flush", popA, 1);
    next();
    sample();
    check("tA_valid77", validA, 1);
    check("tA_data77", dataA, 32'h77);
    next();
    readyA = 1'b1;
    cyc(2);
    check("tA_occ_end", occA, 0);
    check("tA_drain", expA.size(), 0);

    // Asynchronous reset mid-stream with two buffered entries.
    readyB = 1'b0;
    pushB(32'hC1); pushB(32'hC2);
    cyc(3);
    check("t5_occ2", occB, 2);
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", validB, 0);
    check("t5_async_occ", occB, 0);
    check("t5_async_data", dataB, 0);
    check("t5_async_pop", popB, 0);
    repeat (2) @(posedge clk);
    #1;
    sample();
    rst_n = 1'b1;
    next();
    readyB = 1'b1;
    pushB(32'hD1);
    got = 1'b0;
    for (int c = 0; c < 6; c++) begin
      sample();
      if (validB) begin
        check("t5_restart_data", dataB, 32'hD1);
        got = 1'b1;
      end
      next();
      if (got) break;
    end
    check("t5_restart_seen", got, 1);
    cyc(3);
    check("t5_drain", expB.size(), 0);

`ifdef CVA6_FIFO_POP_STAGE_PERF_EN
    // Stall counter over five stalled cycles, then cleared by flush.
    readyA = 1'b0;
    pushA(32'hE1);
    for (int c = 0; c < 6; c++) begin
      sample();
      if (validA) break;
      next();
    end
    check("perf_valid", validA, 1);
    check("perf_stall0", stallA, 0);
    next();
    cyc(4);
    sample();
    check("perf_stall5", stallA, 5);
    check("perf_starve_busy", starveA, 0);
    next();
    flushA = 1'b1;
    next();
    flushA = 1'b0;
    sample();
    check("perf_stall_flush", stallA, 0);
    check("perf_starve_idle", starveA, 1);
    next();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
